// File: rtl/parcel_pkg.sv
// Shared definitions for the parcel-locker front panel: key codes, keypad scanner
// FSM encoding, frame-classification types and the scan-code to key mapping.
package parcel_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  // KEY_NONE doubles as the 7-seg blank code so entry logic can pass it straight through
  localparam logic [3:0] KEY_NONE = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_ENT  = 4'hE;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_DEB = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_kind_t;

  typedef struct packed {
    frame_kind_t kind;
    logic [3:0]  code;
  } frame_res_t;

  // Panel layout: 1 2 3 - / 4 5 6 - / 7 8 9 - / * 0 # -  (right column unused)
  function automatic logic [3:0] scan_to_key(input logic [3:0] scan);
    logic [3:0] key;
    case (scan)
      4'd0:    key = KEY_1;
      4'd1:    key = KEY_2;
      4'd2:    key = KEY_3;
      4'd4:    key = KEY_4;
      4'd5:    key = KEY_5;
      4'd6:    key = KEY_6;
      4'd8:    key = KEY_7;
      4'd9:    key = KEY_8;
      4'd10:   key = KEY_9;
      4'd12:   key = KEY_CLR;
      4'd13:   key = KEY_0;
      4'd14:   key = KEY_ENT;
      default: key = KEY_NONE;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/key_scan.sv
// 4x4 keypad scanner: active-low row drive, synchronised column sampling,
// whole-frame debounce and one key_valid pulse per debounced press.
module key_scan
  import parcel_pkg::*;
#(
  parameter int ROW_CYC    = 4,
  parameter int DEB_FRAMES = 2
) (
  input  logic       clk_1k,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = $clog2(ROW_CYC);
  localparam int DW = $clog2(DEB_FRAMES + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(ROW_CYC - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_FRAMES);

  logic [3:0]    col_meta;
  logic [3:0]    col_s;
  logic [CW-1:0] cyc;
  logic [1:0]    row_idx;
  logic [1:0]    row_idx_next;
  logic [11:0]   acc;
  logic [1:0]    state, state_next;
  logic [3:0]    cand, cand_next;
  logic [DW-1:0] deb, deb_next, deb_inc;
  logic [DW-1:0] rel, rel_next, rel_inc;
  logic [3:0]    code_next;
  logic          valid_next;
  logic          down_next;
  logic          sample_now;
  logic          frame_end;
  frame_res_t    res;

  // Counts closed contacts in a frame; bit index is row*4+col, zero means closed.
  function automatic frame_res_t classify(input logic [15:0] s);
    frame_res_t  r;
    int unsigned zeros;
    r.kind = FR_NONE;
    r.code = '0;
    zeros  = 0;
    for (int i = 0; i < 16; i++) begin
      if (!s[i]) begin
        zeros++;
        r.code = 4'(i);
      end
    end
    if (zeros == 1)     r.kind = FR_SINGLE;
    else if (zeros > 1) r.kind = FR_MULTI;
    return r;
  endfunction

  assign sample_now   = (cyc == CYC_LAST);
  assign frame_end    = sample_now && (row_idx == 2'd3);
  assign row_idx_next = sample_now ? row_idx + 2'd1 : row_idx;
  // Row 3 is classified straight from col_s so the verdict lands on the last sample edge
  assign res          = classify({col_s, acc});
  assign deb_inc      = deb + DW'(1);
  assign rel_inc      = rel + DW'(1);

  always_comb begin
    state_next = state;
    cand_next  = cand;
    deb_next   = deb;
    rel_next   = rel;
    code_next  = key_code;
    valid_next = 1'b0;
    down_next  = key_down;
    if (frame_end) begin
      case (state)
        ST_IDLE: begin
          if (res.kind == FR_SINGLE) begin
            cand_next = res.code;
            deb_next  = DW'(1);
            if (DW'(1) == DEB_MAX) begin
              code_next  = res.code;
              valid_next = 1'b1;
              down_next  = 1'b1;
              rel_next   = '0;
              state_next = ST_HELD;
            end else begin
              state_next = ST_PRESS_DEB;
            end
          end
        end
        ST_PRESS_DEB: begin
          if (res.kind == FR_SINGLE && res.code == cand) begin
            deb_next = deb_inc;
            if (deb_inc == DEB_MAX) begin
              code_next  = cand;
              valid_next = 1'b1;
              down_next  = 1'b1;
              rel_next   = '0;
              state_next = ST_HELD;
            end
          end else begin
            deb_next   = '0;
            state_next = ST_IDLE;
          end
        end
        ST_HELD: begin
          // Anything but an empty frame, even another key, just restarts the release count
          if (res.kind == FR_NONE) begin
            if (rel_inc == DEB_MAX) begin
              rel_next   = '0;
              deb_next   = '0;
              down_next  = 1'b0;
              state_next = ST_IDLE;
            end else begin
              rel_next = rel_inc;
            end
          end else begin
            rel_next = '0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          deb_next   = '0;
          rel_next   = '0;
          down_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1k) begin
    if (!rst) begin
      col_meta  <= 4'hF;
      col_s     <= 4'hF;
      cyc       <= '0;
      row_idx   <= '0;
      row       <= 4'hF;
      acc       <= '0;
      state     <= ST_IDLE;
      cand      <= '0;
      deb       <= '0;
      rel       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      col_meta <= col;
      col_s    <= col_meta;
      if (sample_now) begin
        cyc <= '0;
        case (row_idx)
          2'd0:    acc[3:0]  <= col_s;
          2'd1:    acc[7:4]  <= col_s;
          2'd2:    acc[11:8] <= col_s;
          default: ;
        endcase
      end else begin
        cyc <= cyc + CW'(1);
      end
      row_idx   <= row_idx_next;
      row       <= ~(4'b0001 << row_idx_next);
      state     <= state_next;
      cand      <= cand_next;
      deb       <= deb_next;
      rel       <= rel_next;
      key_code  <= code_next;
      key_valid <= valid_next;
      key_down  <= down_next;
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan: a keypad model closes contacts by scan code and
// every observation goes through check() against hand-derived values.
module tb_key_scan;

  logic        clk_1k = 1'b0;
  logic        rst    = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          errors = 0;
  int          pulse_total = 0;
  logic [3:0]  last_code = '0;
  int          base;

  key_scan dut (
    .clk_1k   (clk_1k),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  always #5 clk_1k = ~clk_1k;

  // A closed key pulls its column low only while its row is driven
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row[r] == 1'b0 && pressed[r*4+c]) col[c] = 1'b0;
  end

  always @(posedge clk_1k) begin
    if (key_valid) begin
      pulse_total <= pulse_total + 1;
      last_code   <= key_code;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1k);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Returns just after a frame-end edge (row has just stepped 0111 -> 1110)
  task automatic sync_frame(input string tag);
    int n;
    n = 0;
    while (row !== 4'b0111 && n < 40) begin tick(1); n++; end
    if (n >= 40) check({tag, "_sync0111"}, row, 4'b0111);
    n = 0;
    while (row !== 4'b1110 && n < 40) begin tick(1); n++; end
    if (n >= 40) check({tag, "_sync1110"}, row, 4'b1110);
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < limit) begin tick(1); n++; end
    check(tag, key_valid, 1);
  endtask

  task automatic wait_down_low(input string tag, input int limit);
    int n;
    n = 0;
    while (key_down !== 1'b0 && n < limit) begin tick(1); n++; end
    check(tag, key_down, 0);
  endtask

  initial begin
    // 1: reset state and row stepping
    rst = 1'b0;
    tick(3);
    check("rst_row", row, 4'b1111);
    check("rst_valid", key_valid, 0);
    check("rst_down", key_down, 0);
    check("rst_code", key_code, 0);
    rst = 1'b1;
    tick(1);  check("scan_row0", row, 4'b1110);
    tick(3);  check("scan_row1", row, 4'b1101);
    tick(4);  check("scan_row2", row, 4'b1011);
    tick(4);  check("scan_row3", row, 4'b0111);
    tick(4);  check("scan_wrap", row, 4'b1110);

    // 2: clean press r1c2, exact frame-aligned latency both ways
    base = pulse_total;
    sync_frame("t2");
    pressed[6] = 1'b1;
    tick(31); check("t2_valid_early", key_valid, 0);
    tick(1);  check("t2_valid", key_valid, 1);
    check("t2_code", key_code, 6);
    check("t2_down", key_down, 1);
    tick(1);  check("t2_valid_pulse", key_valid, 0);
    tick(20);
    sync_frame("t2r");
    pressed[6] = 1'b0;
    tick(31); check("t2_down_hold", key_down, 1);
    tick(1);  check("t2_down_fall", key_down, 0);
    check("t2_count", pulse_total - base, 1);

    // 3: bounce on r0c0, then held
    base = pulse_total;
    sync_frame("t3");
    for (int i = 0; i < 6; i++) begin
      pressed[0] = (i % 2 == 0);
      tick(5);
    end
    pressed[0] = 1'b1;
    check("t3_no_early", pulse_total - base, 0);
    wait_valid("t3_valid", 60);
    check("t3_code", key_code, 0);
    pressed[0] = 1'b0;
    wait_down_low("t3_release", 60);
    check("t3_count", pulse_total - base, 1);

    // 4: two keys never report; the survivor does
    base = pulse_total;
    pressed[9]  = 1'b1;
    pressed[15] = 1'b1;
    tick(100);
    check("t4_multi_nopulse", pulse_total - base, 0);
    check("t4_multi_nodown", key_down, 0);
    pressed[15] = 1'b0;
    wait_valid("t4_valid", 60);
    check("t4_code", key_code, 9);
    pressed = '0;
    wait_down_low("t4_release", 60);
    check("t4_count", pulse_total - base, 1);

    // 5: hold r0c1, roll onto r0c3 without a clean release
    base = pulse_total;
    pressed[1] = 1'b1;
    wait_valid("t5_valid", 60);
    check("t5_code", key_code, 1);
    pressed[3] = 1'b1;
    tick(20);
    pressed[1] = 1'b0;
    tick(60);
    check("t5_no_second", pulse_total - base, 1);
    check("t5_down_held", key_down, 1);
    check("t5_code_kept", last_code, 1);
    pressed[3] = 1'b0;
    wait_down_low("t5_release", 60);
    pressed[3] = 1'b1;
    wait_valid("t5_repress", 60);
    check("t5_repress_code", key_code, 3);
    pressed[3] = 1'b0;
    wait_down_low("t5_release2", 60);
    check("t5_count", pulse_total - base, 2);

    // 6: reset during press debounce on r3c0
    base = pulse_total;
    sync_frame("t6");
    pressed[12] = 1'b1;
    tick(20);
    rst = 1'b0;
    tick(3);
    check("t6_rst_row", row, 4'b1111);
    check("t6_rst_valid", key_valid, 0);
    check("t6_rst_down", key_down, 0);
    check("t6_rst_nopulse", pulse_total - base, 0);
    rst = 1'b1;
    wait_valid("t6_valid", 60);
    check("t6_code", key_code, 12);
    pressed = '0;
    wait_down_low("t6_release", 60);
    check("t6_count", pulse_total - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
